// File: rtl/dist_pkg.sv
// dist_pkg: shared types and constants for the clipping-distortion controller.
package dist_pkg;
  typedef enum logic [1:0] {BYPASS, FADE_IN, ACTIVE, FADE_OUT} state_t;
  typedef logic [2:0] lim_idx_t;
  localparam logic [7:0] UNITY_GAIN = 8'd128;
  localparam logic [15:0] LIM_TABLE [8] = '{16'd250, 16'd500, 16'd750, 16'd1000,
                                            16'd2000, 16'd4000, 16'd8000, 16'd16000};
endpackage

// File: rtl/dist_fade_ramp.sv
// dist_fade_ramp: wet-gain register stepping up or down by FADE_STEP, clamped to 0..UNITY_GAIN.
module dist_fade_ramp
  import dist_pkg::*;
#(
  parameter int FADE_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic       up,
  output logic [7:0] gain,
  output logic [7:0] gain_nxt
);
  localparam logic [8:0] STEP = 9'(FADE_STEP);
  logic [7:0] gain_q, gain_d;
  logic [8:0] sum;
  always_comb begin
    sum = up ? {1'b0, gain_q} + STEP : {1'b0, gain_q} - STEP;
    gain_nxt = up ? ((sum >= {1'b0, UNITY_GAIN}) ? UNITY_GAIN : sum[7:0])
                  : (({1'b0, gain_q} <= STEP) ? 8'd0 : sum[7:0]);
    gain_d = step_en ? gain_nxt : gain_q;
  end
  always_ff @(posedge clk) gain_q <= rst ? 8'd0 : gain_d;
  assign gain = gain_q;
endmodule

// File: rtl/dist_fx_ctrl.sv
// dist_fx_ctrl: wet/dry crossfade FSM and drive/limit settings; optional clip LED under DIST_CLIP_LED_EN.
module dist_fx_ctrl
  import dist_pkg::*;
#(
  parameter int MAX_DRIVE     = 4,
  parameter int DEFAULT_DRIVE = 4,
  parameter int DEFAULT_LIM   = 3,
  parameter int FADE_STEP     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic        enable_sw,
  input  logic        drive_up,
  input  logic        drive_dn,
  input  logic        lim_up,
  input  logic        lim_dn,
`ifdef DIST_CLIP_LED_EN
  input  logic        clip_flag,
  output logic        clip_led,
`endif
  output logic [2:0]  drive_shift,
  output logic [15:0] limit,
  output logic [7:0]  mix_gain,
  output logic        fx_active,
  output logic        busy
);
  localparam logic [2:0] MAX_D = 3'(MAX_DRIVE);
  state_t     state_q, state_d;
  logic       en_m_q, en_s_q;
  logic       du_q, dd_q, lu_q, ld_q, du_d, dd_d, lu_d, ld_d;
  logic [2:0] drive_q, drive_d;
  lim_idx_t   lim_q, lim_d;
  logic [15:0] limit_q, limit_d;
  logic       step_en;
  logic [7:0] gain_nxt;
  dist_fade_ramp #(.FADE_STEP(FADE_STEP)) u_ramp (
    .clk(clk), .rst(rst), .step_en(step_en), .up(en_s_q), .gain(mix_gain), .gain_nxt(gain_nxt)
  );
  // The ramp always steps toward the synchronized switch, so reversals start from the current gain.
  always_comb begin
    step_en = sample_tick && ((state_q == FADE_IN) || (state_q == FADE_OUT) ||
              (state_q == BYPASS && en_s_q) || (state_q == ACTIVE && !en_s_q));
    state_d = !step_en ? state_q
            : en_s_q ? ((gain_nxt == UNITY_GAIN) ? ACTIVE : FADE_IN)
            : ((gain_nxt == 8'd0) ? BYPASS : FADE_OUT);
    du_d = !sample_tick && (du_q || drive_up);
    dd_d = !sample_tick && (dd_q || drive_dn);
    lu_d = !sample_tick && (lu_q || lim_up);
    ld_d = !sample_tick && (ld_q || lim_dn);
    drive_d = !sample_tick ? drive_q
            : ((du_q || drive_up) && !(dd_q || drive_dn) && drive_q < MAX_D) ? drive_q + 3'd1
            : ((dd_q || drive_dn) && !(du_q || drive_up) && drive_q != 3'd0) ? drive_q - 3'd1
            : drive_q;
    lim_d = !sample_tick ? lim_q
          : ((lu_q || lim_up) && !(ld_q || lim_dn) && lim_q != 3'd7) ? lim_q + 3'd1
          : ((ld_q || lim_dn) && !(lu_q || lim_up) && lim_q != 3'd0) ? lim_q - 3'd1
          : lim_q;
    limit_d = LIM_TABLE[lim_d];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BYPASS;
      {en_m_q, en_s_q} <= 2'b00;
      {du_q, dd_q, lu_q, ld_q} <= 4'b0000;
      drive_q <= 3'(DEFAULT_DRIVE);
      lim_q <= lim_idx_t'(DEFAULT_LIM);
      limit_q <= LIM_TABLE[DEFAULT_LIM];
    end else begin
      state_q <= state_d;
      {en_m_q, en_s_q} <= {enable_sw, en_m_q};
      {du_q, dd_q, lu_q, ld_q} <= {du_d, dd_d, lu_d, ld_d};
      drive_q <= drive_d;
      lim_q <= lim_d;
      limit_q <= limit_d;
    end
  end
  assign drive_shift = drive_q;
  assign limit = limit_q;
  assign fx_active = state_q == ACTIVE;
  assign busy = (state_q == FADE_IN) || (state_q == FADE_OUT);
`ifdef DIST_CLIP_LED_EN
  // Loaded with 4801 so the LED covers the clip tick plus 4800 further ticks.
  logic [12:0] clip_q, clip_d;
  always_comb clip_d = !sample_tick ? clip_q : clip_flag ? 13'd4801 : clip_q - 13'(clip_q != 13'd0);
  always_ff @(posedge clk) clip_q <= rst ? 13'd0 : clip_d;
  assign clip_led = clip_q != 13'd0;
`endif
endmodule

// File: tb/tb_dist_fx_ctrl.sv
// tb_dist_fx_ctrl: vector table for settings requests plus scoreboarded fade sequences.
module tb_dist_fx_ctrl;
  logic clk = 0, rst = 1, sample_tick = 0, enable_sw = 0;
  logic drive_up = 0, drive_dn = 0, lim_up = 0, lim_dn = 0, clip_flag = 0;
  logic clip_led;
  logic [2:0] drive_shift;
  logic [15:0] limit;
  logic [7:0] mix_gain;
  logic fx_active, busy;
  int total = 0, bad = 0, g = 0;
  typedef struct {int du; int dd; int lu; int ld; int drive; int lim;} vec_t;
  typedef struct {int gain; int bsy; int fx;} rexp_t;
  vec_t vecs[$], tq[$];
  rexp_t rq[$];
  always #5 clk = ~clk;
  dist_fx_ctrl dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .enable_sw(enable_sw),
    .drive_up(drive_up), .drive_dn(drive_dn), .lim_up(lim_up), .lim_dn(lim_dn),
`ifdef DIST_CLIP_LED_EN
    .clip_flag(clip_flag), .clip_led(clip_led),
`endif
    .drive_shift(drive_shift), .limit(limit), .mix_gain(mix_gain),
    .fx_active(fx_active), .busy(busy)
  );
`ifndef DIST_CLIP_LED_EN
  assign clip_led = 1'b0;
`endif
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk) sample_tick = 1;
    @(negedge clk) sample_tick = 0;
  endtask
  task automatic pulse(input logic [3:0] m);
    @(negedge clk) {drive_up, drive_dn, lim_up, lim_dn} = m;
    @(negedge clk) {drive_up, drive_dn, lim_up, lim_dn} = 4'b0;
  endtask
  task automatic fade(input int n, input logic e);
    rexp_t r;
    enable_sw = e;
    repeat (3) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      g = e ? ((g + 4 > 128) ? 128 : g + 4) : ((g < 4) ? 0 : g - 4);
      r.gain = g;
      r.bsy = e ? int'(g < 128) : int'(g > 0);
      r.fx = int'(e && g == 128);
      rq.push_back(r);
      tick();
      r = rq.pop_front();
      chk("mix_gain", mix_gain, r.gain);
      chk("busy", busy, r.bsy);
      chk("fx_active", fx_active, r.fx);
      repeat (8) @(negedge clk);
    end
  endtask
  initial begin
    vec_t v;
    int pd, pl;
    vecs = '{'{0,1,0,0,3,1000}, '{3,0,0,0,4,1000}, '{3,0,0,0,4,1000}, '{0,0,1,1,4,1000},
             '{0,0,0,0,4,1000}, '{0,0,1,0,4,2000}, '{0,0,2,0,4,4000}, '{0,0,1,0,4,8000},
             '{0,0,3,0,4,16000}, '{0,0,1,0,4,16000}, '{1,1,0,2,4,8000}, '{0,2,0,1,3,4000},
             '{0,1,0,1,2,2000}, '{0,1,0,1,1,1000}, '{0,1,0,1,0,750}, '{0,1,0,1,0,500},
             '{0,0,0,1,0,250}, '{0,0,0,1,0,250}, '{1,0,0,0,1,250}};
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_gain", mix_gain, 0);
    chk("rst_drive", drive_shift, 4);
    chk("rst_limit", limit, 1000);
    chk("rst_fx", fx_active, 0);
    chk("rst_busy", busy, 0);
    pd = 4; pl = 1000;
    foreach (vecs[i]) begin
      tq.push_back(vecs[i]);
      for (int c = 0; c < 3; c++)
        if (c < vecs[i].du || c < vecs[i].dd || c < vecs[i].lu || c < vecs[i].ld)
          pulse({c < vecs[i].du, c < vecs[i].dd, c < vecs[i].lu, c < vecs[i].ld});
      chk("hold_drive", drive_shift, pd);
      chk("hold_limit", limit, pl);
      tick();
      v = tq.pop_front();
      chk("vec_drive", drive_shift, v.drive);
      chk("vec_limit", limit, v.lim);
      chk("vec_gain", mix_gain, 0);
      pd = v.drive; pl = v.lim;
    end
    @(negedge clk) begin drive_up = 1; sample_tick = 1; end
    @(negedge clk) begin drive_up = 0; sample_tick = 0; end
    chk("same_cycle_up", drive_shift, 2);
    tick();
    chk("flags_cleared", drive_shift, 2);
    fade(32, 1);
    fade(2, 1);
    fade(16, 0);
    fade(2, 1);
    fade(18, 0);
    fade(10, 1);
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    chk("midrst_gain", mix_gain, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fx", fx_active, 0);
    chk("midrst_drive", drive_shift, 4);
    chk("midrst_limit", limit, 1000);
    enable_sw = 0;
    g = 0;
    fade(2, 0);
`ifdef DIST_CLIP_LED_EN
    clip_flag = 1; tick(); clip_flag = 0;
    chk("clip_on", clip_led, 1);
    repeat (4800) tick();
    chk("clip_hold_end", clip_led, 1);
    tick();
    chk("clip_off", clip_led, 0);
    clip_flag = 1; tick(); clip_flag = 0;
    repeat (1999) tick();
    clip_flag = 1; tick(); clip_flag = 0;
    repeat (4800) tick();
    chk("clip_restart_hold", clip_led, 1);
    tick();
    chk("clip_restart_off", clip_led, 0);
`endif
    chk("sb_empty", rq.size() + tq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
